// File: rtl/dht_pkg.sv
// Shared DHT11 definitions: scheduler state encoding, 40-bit frame field
// offsets and the frame checksum test used by the reader and display logic.
package dht_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_TRIG    = 3'd1,
    ST_BUSY    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_FAIL    = 3'd4,
    ST_WAIT    = 3'd5
  } dht_state_e;

  localparam int RH_INT_LSB = 32;
  localparam int RH_DEC_LSB = 24;
  localparam int T_INT_LSB  = 16;
  localparam int T_DEC_LSB  = 8;
  localparam int CSUM_LSB   = 0;

  // The checksum is the low byte of the sum of the four data bytes.
  function automatic logic dht_checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[RH_INT_LSB +: 8] + frame[RH_DEC_LSB +: 8]
        + frame[T_INT_LSB +: 8] + frame[T_DEC_LSB +: 8];
    return sum == frame[CSUM_LSB +: 8];
  endfunction

endpackage

// File: rtl/dht_ms_tick.sv
// Millisecond prescaler: one-cycle tick every TICKS_PER_MS cycles, with a
// synchronous restart so a new wait always begins on a full millisecond.
module dht_ms_tick #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Not gated by restart: the tick itself may be what causes the state change.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/dht_sample_scheduler.sv
// DHT11 sample sequencer: power-up wait, periodic triggering of the bit-level
// reader with a watchdog, checksum validation, bounded retry and result hold.
module dht_sample_scheduler
  import dht_pkg::*;
#(
  parameter int TICKS_PER_MS = 50000,
  parameter int POWERUP_MS   = 1000,
  parameter int PERIOD_MS    = 2000,
  parameter int RETRY_MS     = 100,
  parameter int TIMEOUT_MS   = 10,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_now,
  output logic        rd_start,
  input  logic        rd_busy,
  input  logic        rd_done,
  input  logic        rd_err,
  input  logic [39:0] rd_data,
  output logic [7:0]  humid,
  output logic [7:0]  temp,
  output logic        valid,
  output logic        fault,
  output logic        sample_stb,
  output logic [7:0]  err_cnt,
  output logic [2:0]  dbg_state
);

  // Reader handshake: rd_start is a one-cycle request; the reader answers
  // with exactly one rd_done or rd_err pulse, honoured only while in BUSY.
  // If both pulse together the error wins.

  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);
  localparam logic [16:0]   POWERUP_LIM = 17'(POWERUP_MS);
  localparam logic [16:0]   PERIOD_LIM  = 17'(PERIOD_MS);
  localparam logic [16:0]   RETRY_LIM   = 17'(RETRY_MS);
  localparam logic [16:0]   TIMEOUT_LIM = 17'(TIMEOUT_MS);

  dht_state_e    state_q, state_d;
  logic          tick;
  logic          restart;
  logic [15:0]   ms_cnt;
  logic [16:0]   ms_next;
  logic [16:0]   wait_lim;
  logic [RW-1:0] retry_q;
  logic          pending_q;
  logic          wait_short_q;
  logic [39:0]   frame_q;
  logic          csum_ok;
  logic          unused_busy;

  assign unused_busy = rd_busy;
  assign dbg_state   = state_q;
  assign ms_next     = {1'b0, ms_cnt} + 17'd1;
  assign csum_ok     = dht_checksum_ok(frame_q);
  // A pending manual request shortens a long WAIT to the retry gap.
  assign wait_lim    = (wait_short_q || pending_q) ? RETRY_LIM : PERIOD_LIM;
  assign restart     = (state_d != state_q);

  dht_ms_tick #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_POWERUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_POWERUP: if (tick && ms_next >= POWERUP_LIM) state_d = ST_TRIG;
      ST_TRIG:    state_d = ST_BUSY;
      ST_BUSY: begin
        if (rd_err) begin
          state_d = ST_FAIL;
        end else if (rd_done) begin
          state_d = ST_CHECK;
        end else if (tick && ms_next >= TIMEOUT_LIM) begin
          state_d = ST_FAIL;
        end
      end
      ST_CHECK:   state_d = csum_ok ? ST_WAIT : ST_FAIL;
      ST_FAIL:    state_d = ST_WAIT;
      ST_WAIT:    if (tick && ms_next >= wait_lim) state_d = ST_TRIG;
      default:    state_d = ST_POWERUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_cnt       <= '0;
      retry_q      <= '0;
      pending_q    <= 1'b0;
      wait_short_q <= 1'b0;
      frame_q      <= '0;
      rd_start     <= 1'b0;
      humid        <= '0;
      temp         <= '0;
      valid        <= 1'b0;
      fault        <= 1'b0;
      sample_stb   <= 1'b0;
      err_cnt      <= '0;
    end else begin
      rd_start   <= (state_q == ST_TRIG);
      sample_stb <= 1'b0;

      if (restart) begin
        ms_cnt <= '0;
      end else if (tick) begin
        ms_cnt <= ms_next[15:0];
      end

      if (state_q == ST_TRIG) begin
        pending_q <= 1'b0;
      end else if (req_now) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        ST_BUSY: begin
          if (rd_done && !rd_err) frame_q <= rd_data;
        end
        ST_CHECK: begin
          if (csum_ok) begin
            humid        <= frame_q[RH_INT_LSB +: 8];
            temp         <= frame_q[T_INT_LSB +: 8];
            valid        <= 1'b1;
            fault        <= 1'b0;
            retry_q      <= '0;
            sample_stb   <= 1'b1;
            wait_short_q <= 1'b0;
          end
        end
        ST_FAIL: begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (retry_q == RETRY_LAST) begin
            fault   <= 1'b1;
            retry_q <= '0;
          end else begin
            retry_q <= retry_q + 1'b1;
          end
          wait_short_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_sample_scheduler.sv
// Bench for dht_sample_scheduler: directed scenarios plus randomized reads,
// checked against a transaction-level model of the sequencer's rules.
module tb_dht_sample_scheduler;

  localparam int TPM    = 10;
  localparam int PU_MS  = 5;
  localparam int PER_MS = 20;
  localparam int RET_MS = 4;
  localparam int TO_MS  = 3;
  localparam int MAX_R  = 3;
  localparam int BOUND  = 2000;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_TO   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_now = 1'b0;
  logic        rd_busy = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_err = 1'b0;
  logic [39:0] rd_data = '0;
  logic        rd_start;
  logic [7:0]  humid;
  logic [7:0]  temp;
  logic        valid;
  logic        fault;
  logic        sample_stb;
  logic [7:0]  err_cnt;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] exp_q[$];
  int m_humid, m_temp, m_valid, m_fault, m_retry, m_err;

  // clock / reset
  always #5 clk = ~clk;

  dht_sample_scheduler #(
    .TICKS_PER_MS(TPM),
    .POWERUP_MS  (PU_MS),
    .PERIOD_MS   (PER_MS),
    .RETRY_MS    (RET_MS),
    .TIMEOUT_MS  (TO_MS),
    .MAX_RETRY   (MAX_R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_now   (req_now),
    .rd_start  (rd_start),
    .rd_busy   (rd_busy),
    .rd_done   (rd_done),
    .rd_err    (rd_err),
    .rd_data   (rd_data),
    .humid     (humid),
    .temp      (temp),
    .valid     (valid),
    .fault     (fault),
    .sample_stb(sample_stb),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model
  function automatic bit frame_good(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic logic [39:0] rand_frame(input bit good);
    logic [7:0] b [4];
    logic [7:0] cs;
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom_range(0, 99));
      s += int'(b[i]);
    end
    cs = 8'(s % 256);
    if (!good) cs = cs + 8'($urandom_range(1, 255));
    return {b[0], b[1], b[2], b[3], cs};
  endfunction

  task automatic model_reset();
    m_humid = 0; m_temp = 0; m_valid = 0; m_fault = 0; m_retry = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_resp(input bit good);
    if (good) begin
      m_humid = 0; m_temp = 0;
      m_valid = 1; m_fault = 0; m_retry = 0;
    end else begin
      if (m_err < 255) m_err++;
      m_retry++;
      if (m_retry == MAX_R) begin
        m_fault = 1;
        m_retry = 0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_start"}, rd_start, 0);
    chk({tag, "_humid"}, humid, 0);
    chk({tag, "_temp"}, temp, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_stb"}, sample_stb, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // From reset release: count edges to the first rd_start, outputs held at reset.
  task automatic wait_first(input int req_at);
    int n;
    bit got, quiet;
    n = 0; got = 0; quiet = 1;
    while (!got && n < BOUND) begin
      if (n == req_at) req_now = 1'b1;
      step();
      n++;
      req_now = 1'b0;
      if (rd_start) got = 1;
      else if (humid != 0 || temp != 0 || valid || fault || sample_stb || err_cnt != 0) quiet = 0;
    end
    chk("first_trig_latency", n, PU_MS * TPM + 1);
    chk("quiet_until_trig", quiet, 1);
  endtask

  // Called just after rd_start is seen. Answers the read (or not), then runs
  // to the next rd_start and checks latency, strobe and held outputs.
  // The answering edge is n_resp; one cycle of CHECK or FAIL follows, then
  // WAIT for the gap, then TRIG and the registered rd_start.
  task automatic do_read(input int kind, input logic [39:0] f, input int d,
                         input int req_at, input int stray_at);
    int n, stb_cnt, stb_at, n_resp, gap_ms, exp_n;
    bit got, good, chk_fail;
    logic [15:0] e;
    n = 0; stb_cnt = 0; stb_at = -1; got = 0;
    good     = (kind == K_DONE) && frame_good(f);
    chk_fail = (kind == K_DONE) && !good;
    n_resp   = (kind == K_TO) ? TO_MS * TPM : d + 1;
    gap_ms   = (good && req_at < 0) ? PER_MS : RET_MS;
    exp_n    = n_resp + gap_ms * TPM + 2 + (chk_fail ? 1 : 0);
    model_resp(good);
    if (good) begin
      m_humid = int'(f[39:32]);
      m_temp  = int'(f[23:16]);
      exp_q.push_back({f[39:32], f[23:16]});
    end
    rd_busy = 1'b1;
    while (!got && n < BOUND) begin
      if (kind != K_TO && n == d) begin
        rd_data = f;
        rd_done = (kind != K_ERR);
        rd_err  = (kind != K_DONE);
      end
      if (n == req_at) req_now = 1'b1;
      if (n == stray_at) begin
        rd_data = 40'h01_00_02_00_03;
        rd_done = 1'b1;
      end
      step();
      n++;
      if (rd_done || rd_err) rd_busy = 1'b0;
      rd_done = 1'b0; rd_err = 1'b0; req_now = 1'b0;
      if (sample_stb) begin
        stb_cnt++;
        stb_at = n;
      end
      if (rd_start) got = 1;
    end
    rd_busy = 1'b0;
    chk("trig_latency", n, exp_n);
    chk("stb_count", stb_cnt, good ? 1 : 0);
    if (good) begin
      chk("stb_cycle", stb_at, n_resp + 1);
      e = exp_q.pop_front();
      chk("scoreboard_hum_temp", {humid, temp}, e);
    end
    chk("humid", humid, m_humid);
    chk("temp", temp, m_temp);
    chk("valid", valid, m_valid);
    chk("fault", fault, m_fault);
    chk("err_cnt", err_cnt, m_err);
  endtask

  initial begin
    int kind, r;
    bit good;

    // reset state, reader noise during reset
    model_reset();
    #2 rst = 1'b1;
    rd_done = 1'b1;
    rd_data = 40'h37_00_19_00_50;
    repeat (3) step();
    rd_done = 1'b0;
    check_reset_outputs("reset");

    // power-up with a manual request that must not trigger early
    rst = 1'b0;
    wait_first(20);

    // good frame, then three bad checksums raising fault, then recovery
    do_read(K_DONE, 40'h37_00_19_00_50, 3, -1, -1);
    for (int i = 0; i < 3; i++) begin
      do_read(K_DONE, 40'h37_00_19_00_51, $urandom_range(0, 20), -1, -1);
    end
    chk("fault_after_three", fault, 1);
    do_read(K_DONE, 40'h2A_00_16_00_40, 5, -1, -1);
    chk("fault_cleared", fault, 0);

    // watchdog, done+err collision, plain error
    do_read(K_TO, 40'h0, 0, -1, -1);
    do_read(K_BOTH, 40'h20_00_10_00_30, 4, -1, -1);
    do_read(K_ERR, 40'h0, 7, -1, -1);

    // manual request 2 ms into a long wait, plus a stray rd_done in WAIT
    do_read(K_DONE, 40'h30_05_12_03_4A, 0, 21, 10);

    // randomized reads
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      kind = (r < 6) ? K_DONE : (r < 8) ? K_ERR : (r == 8) ? K_BOTH : K_TO;
      good = ($urandom_range(0, 9) < 7);
      do_read(kind, rand_frame(good), $urandom_range(0, 20), -1, -1);
    end

    // make sure valid=1, then reset in BUSY
    do_read(K_DONE, 40'h41_00_17_00_58, 2, -1, -1);
    chk("valid_before_reset", valid, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    rd_data = 40'h37_00_19_00_50;
    rd_done = 1'b1;
    repeat (3) step();
    rd_done = 1'b0;
    chk("reset_ignores_done_valid", valid, 0);
    chk("reset_ignores_done_humid", humid, 0);
    rst = 1'b0;
    model_reset();
    wait_first(-1);

    // error counter saturation
    for (int i = 0; i < 257; i++) begin
      do_read(K_ERR, 40'h0, 0, -1, -1);
    end
    chk("err_cnt_saturated", err_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
